idex_stage: RTL

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/idex_stage_if.sv | 56 +++++
 rtl/idex_stage.sv | 101 ++++++++++
 2 files changed

// File: rtl/idex_stage_if.sv
// idex_stage_if: the bus around the ID/EX pipeline register.
//   ID side     : id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
//                 id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_ctrl
//   WB side     : wb_regWrite, wb_rd, wb_data (register-file write-through)
//   Control     : flush (EX redirect), ex_hold (downstream stall)
//   EX side     : ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
//                 IDEX_rs1, IDEX_rs2, ex_rd, ex_ctrl
//   Status      : stall_ifid (hold PC and IF/ID), bubble_cnt
// master = the pipeline around the stage, slave = idex_stage itself.
interface idex_stage_if #(
  parameter int CTRL_W = 8
);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_rs1_data;
  logic [31:0]       id_rs2_data;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_regWrite;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              flush;
  logic              ex_hold;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_rs1_data;
  logic [31:0]       ex_rs2_data;
  logic [31:0]       ex_imm;
  logic [4:0]        IDEX_rs1;
  logic [4:0]        IDEX_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              stall_ifid;
  logic [15:0]       bubble_cnt;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_ctrl,
           wb_regWrite, wb_rd, wb_data, flush, ex_hold,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           IDEX_rs1, IDEX_rs2, ex_rd, ex_ctrl, stall_ifid, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_ctrl,
           wb_regWrite, wb_rd, wb_data, flush, ex_hold,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           IDEX_rs1, IDEX_rs2, ex_rd, ex_ctrl, stall_ifid, bubble_cnt
  );
endinterface

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use hazard detection,
// bubble insertion, register-file write-through bypass and a saturating
// bubble counter.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : idex_stage_if.slave (ID inputs, WB bypass, flush/ex_hold,
//         registered EX outputs, stall_ifid, bubble_cnt)
// Per-edge priority: flush > ex_hold > load-use bubble > capture.
module idex_stage #(
  parameter int CTRL_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  idex_stage_if.slave  bus
);

  logic              r_ex_valid;
  logic [31:0]       r_ex_pc;
  logic [31:0]       r_ex_rs1_data;
  logic [31:0]       r_ex_rs2_data;
  logic [31:0]       r_ex_imm;
  logic [4:0]        r_idex_rs1;
  logic [4:0]        r_idex_rs2;
  logic [4:0]        r_ex_rd;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [15:0]       r_bubble_cnt;

  logic              w_load_use;
  logic              w_byp_rs1;
  logic              w_byp_rs2;
  logic [31:0]       w_rs1_data;
  logic [31:0]       w_rs2_data;

  // EX holds a load (ctrl[1] = memRead) whose non-x0 target is read by ID.
  assign w_load_use = r_ex_valid & r_ex_ctrl[1] & (r_ex_rd != 5'd0) & bus.id_valid &
                      ((bus.id_use_rs1 & (bus.id_rs1 == r_ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == r_ex_rd)));

  // A flush kills the dependent instruction anyway, so it need not stall.
  assign bus.stall_ifid = (w_load_use & ~bus.flush) | bus.ex_hold;

  // WB writes the register file in the same cycle ID reads it; take the new
  // value. x0 is hardwired zero and never bypassed.
  assign w_byp_rs1  = bus.wb_regWrite & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rs1);
  assign w_byp_rs2  = bus.wb_regWrite & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rs2);
  assign w_rs1_data = w_byp_rs1 ? bus.wb_data : bus.id_rs1_data;
  assign w_rs2_data = w_byp_rs2 ? bus.wb_data : bus.id_rs2_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_idex_rs1    <= '0;
      r_idex_rs2    <= '0;
      r_ex_rd       <= '0;
      r_ex_ctrl     <= '0;
      r_bubble_cnt  <= '0;
    end else if (bus.flush) begin
      // data fields are don't-care after a flush; leave them as they are
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
    end else if (bus.ex_hold) begin
      // freeze everything
    end else if (w_load_use) begin
      // bubble clears ctrl[1], so the hazard cannot re-fire next cycle
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_rd    <= '0;
      r_idex_rs1 <= '0;
      r_idex_rs2 <= '0;
      if (r_bubble_cnt != 16'hFFFF) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end else begin
      r_ex_valid    <= bus.id_valid;
      r_ex_pc       <= bus.id_pc;
      r_ex_rs1_data <= w_rs1_data;
      r_ex_rs2_data <= w_rs2_data;
      r_ex_imm      <= bus.id_imm;
      r_idex_rs1    <= bus.id_rs1;
      r_idex_rs2    <= bus.id_rs2;
      r_ex_rd       <= bus.id_rd;
      r_ex_ctrl     <= bus.id_valid ? bus.id_ctrl : '0;
    end
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_rs1_data = r_ex_rs1_data;
  assign bus.ex_rs2_data = r_ex_rs2_data;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.IDEX_rs1    = r_idex_rs1;
  assign bus.IDEX_rs2    = r_idex_rs2;
  assign bus.ex_rd       = r_ex_rd;
  assign bus.ex_ctrl     = r_ex_ctrl;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule
